// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded operands and control for EX; optional IDEX_PERF_CNT_EN adds bubble/stall counters.
// Latency: one clk from id_* to ex_*; every output is registered, with no input-to-output path.
// Backpressure: stall holds all contents, flush loads a bubble, and a synchronous rst_n overrides both.
module id_ex_pipe_reg #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   id_valid,
    input  logic [WORD_LENGTH-1:0] id_pc_plus4,
    input  logic [WORD_LENGTH-1:0] id_read_data1,
    input  logic [WORD_LENGTH-1:0] id_read_data2,
    input  logic [WORD_LENGTH-1:0] id_sign_ext_imm,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic [4:0]             id_rd,
    input  logic [2:0]             id_alu_op,
    input  logic                   id_alu_src,
    input  logic                   id_reg_dst,
    input  logic                   id_mem_read,
    input  logic                   id_mem_write,
    input  logic                   id_mem_to_reg,
    input  logic                   id_reg_write,
    output logic                   ex_valid,
    output logic [WORD_LENGTH-1:0] ex_pc_plus4,
    output logic [WORD_LENGTH-1:0] ex_read_data1,
    output logic [WORD_LENGTH-1:0] ex_read_data2,
    output logic [WORD_LENGTH-1:0] ex_sign_ext_imm,
    output logic [4:0]             ex_rs,
    output logic [4:0]             ex_rt,
    output logic [4:0]             ex_rd,
    output logic [2:0]             ex_alu_op,
    output logic                   ex_alu_src,
    output logic                   ex_reg_dst,
    output logic                   ex_mem_read,
    output logic                   ex_mem_write,
    output logic                   ex_mem_to_reg,
`ifdef IDEX_PERF_CNT_EN
    output logic                   ex_reg_write,
    output logic [15:0]            ex_bubble_cnt,
    output logic [15:0]            ex_stall_cnt
`else
    output logic                   ex_reg_write
`endif
);

    typedef struct packed {
        logic                   valid;
        logic [WORD_LENGTH-1:0] pc_plus4;
        logic [WORD_LENGTH-1:0] read_data1;
        logic [WORD_LENGTH-1:0] read_data2;
        logic [WORD_LENGTH-1:0] sign_ext_imm;
        logic [4:0]             rs;
        logic [4:0]             rt;
        logic [4:0]             rd;
        logic [2:0]             alu_op;
        logic                   alu_src;
        logic                   reg_dst;
        logic                   mem_read;
        logic                   mem_write;
        logic                   mem_to_reg;
        logic                   reg_write;
    } idex_t;

    idex_t id_dat;
    idex_t ex_dat;

    // State-changing control is squashed for a non-instruction; the datapath still loads.
    always_comb begin
        id_dat              = '0;
        id_dat.valid        = id_valid;
        id_dat.pc_plus4     = id_pc_plus4;
        id_dat.read_data1   = id_read_data1;
        id_dat.read_data2   = id_read_data2;
        id_dat.sign_ext_imm = id_sign_ext_imm;
        id_dat.rs           = id_rs;
        id_dat.rt           = id_rt;
        id_dat.rd           = id_rd;
        id_dat.alu_op       = id_alu_op;
        id_dat.alu_src      = id_alu_src;
        id_dat.reg_dst      = id_reg_dst;
        id_dat.mem_read     = id_mem_read  & id_valid;
        id_dat.mem_write    = id_mem_write & id_valid;
        id_dat.mem_to_reg   = id_mem_to_reg;
        id_dat.reg_write    = id_reg_write & id_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_dat <= '0;
        end else if (flush) begin
            ex_dat <= '0;
        end else if (!stall) begin
            ex_dat <= id_dat;
        end
    end

    assign ex_valid        = ex_dat.valid;
    assign ex_pc_plus4     = ex_dat.pc_plus4;
    assign ex_read_data1   = ex_dat.read_data1;
    assign ex_read_data2   = ex_dat.read_data2;
    assign ex_sign_ext_imm = ex_dat.sign_ext_imm;
    assign ex_rs           = ex_dat.rs;
    assign ex_rt           = ex_dat.rt;
    assign ex_rd           = ex_dat.rd;
    assign ex_alu_op       = ex_dat.alu_op;
    assign ex_alu_src      = ex_dat.alu_src;
    assign ex_reg_dst      = ex_dat.reg_dst;
    assign ex_mem_read     = ex_dat.mem_read;
    assign ex_mem_write    = ex_dat.mem_write;
    assign ex_mem_to_reg   = ex_dat.mem_to_reg;
    assign ex_reg_write    = ex_dat.reg_write;

`ifdef IDEX_PERF_CNT_EN
    logic [15:0] bubble_cnt;
    logic [15:0] stall_cnt;

    // Saturating counters: a stall that coincides with a flush counts as a bubble only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (flush && bubble_cnt != 16'hFFFF)
                bubble_cnt <= bubble_cnt + 16'd1;
            if (stall && !flush && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign ex_bubble_cnt = bubble_cnt;
    assign ex_stall_cnt  = stall_cnt;
`endif

endmodule
